// File: rtl/mips_run_monitor_pkg.sv
// Shared types for the MIPS CPU run monitor: FSM states, status codes and a
// width helper for the reset/active-wait phase counter.
package mips_run_monitor_pkg;

  localparam int unsigned STATE_WIDTH  = 3;
  localparam int unsigned STATUS_WIDTH = 2;

  typedef enum logic [STATE_WIDTH-1:0] {
    ST_IDLE     = 3'd0,
    ST_RST      = 3'd1,
    ST_WAIT_ACT = 3'd2,
    ST_RUN      = 3'd3,
    ST_DRAIN    = 3'd4,
    ST_DONE     = 3'd5
  } run_state_t;

  typedef enum logic [STATUS_WIDTH-1:0] {
    STATUS_OK        = 2'd0,
    STATUS_NO_ACTIVE = 2'd1,
    STATUS_TIMEOUT   = 2'd2,
    STATUS_MISMATCH  = 2'd3
  } run_status_t;

  // Bits needed to hold values 0..max_val (at least one bit).
  function automatic int unsigned phase_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/mips_run_counter.sv
// Saturating, clearable up-counter; hit_c flags that the value being loaded
// on this edge equals cmp_i.
module mips_run_counter #(
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr_i,
  input  logic                 inc_i,
  input  logic [CNT_WIDTH-1:0] cmp_i,
  output logic [CNT_WIDTH-1:0] cnt_o,
  output logic                 hit_c
);

  logic [CNT_WIDTH-1:0] cnt_q;
  logic [CNT_WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != {CNT_WIDTH{1'b1}})) begin
      cnt_d = cnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;
  assign hit_c = (cnt_d == cmp_i);

endmodule

// File: rtl/mips_cpu_run_monitor.sv
// Run control and result capture for one MIPS CPU: reset, wait for active,
// count to halt or timeout, capture v0. MIPS_RUN_MONITOR_COMPARE_EN adds the v0 check.
module mips_cpu_run_monitor
  import mips_run_monitor_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned CNT_WIDTH    = 32,
  parameter int unsigned RESET_CYCLES = 1,
  parameter int unsigned ACTIVE_WAIT  = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [CNT_WIDTH-1:0]  timeout_cycles,
  input  logic [DATA_WIDTH-1:0] expected_v0,
  input  logic                  cpu_active,
  input  logic [DATA_WIDTH-1:0] cpu_register_v0,
  output logic                  cpu_reset,
  output logic                  cpu_clk_enable,
  output logic                  busy,
  output logic                  done,
  output logic [1:0]            status,
  output logic [DATA_WIDTH-1:0] result_v0,
  output logic [CNT_WIDTH-1:0]  cycle_count
);

  localparam int unsigned PH_WIDTH = phase_width(RESET_CYCLES + ACTIVE_WAIT);
  localparam logic [PH_WIDTH-1:0] RST_LAST  = PH_WIDTH'(RESET_CYCLES - 1);
  localparam logic [PH_WIDTH-1:0] WAIT_LAST = PH_WIDTH'(ACTIVE_WAIT);

  run_state_t            state_q, state_d;
  run_status_t           status_q, status_d;
  logic                  cpu_reset_q, cpu_reset_d;
  logic                  cpu_clk_enable_q, cpu_clk_enable_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [DATA_WIDTH-1:0] result_v0_q, result_v0_d;
  logic [CNT_WIDTH-1:0]  timeout_q, timeout_d;
  logic [PH_WIDTH-1:0]   ph_q, ph_d;
  logic                  start_acc_c;
  logic                  cnt_inc_c;
  logic                  cnt_hit_c;
  logic                  mismatch_c;
  logic [CNT_WIDTH-1:0]  cnt_val;

  assign start_acc_c = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign cnt_inc_c   = (state_q == ST_RUN) && cpu_active;

  mips_run_counter #(.CNT_WIDTH(CNT_WIDTH)) u_counter (
    .clk   (clk),
    .rst   (reset),
    .clr_i (start_acc_c),
    .inc_i (cnt_inc_c),
    .cmp_i (timeout_q),
    .cnt_o (cnt_val),
    .hit_c (cnt_hit_c)
  );

`ifdef MIPS_RUN_MONITOR_COMPARE_EN
  logic [DATA_WIDTH-1:0] expected_q, expected_d;

  assign expected_d = start_acc_c ? expected_v0 : expected_q;
  assign mismatch_c = (cpu_register_v0 != expected_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      expected_q <= '0;
    end else begin
      expected_q <= expected_d;
    end
  end
`else
  logic unused_expected;

  assign unused_expected = ^expected_v0;
  assign mismatch_c      = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state; a halt (active low) takes priority over the timeout hit.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE: if (start) state_d = ST_RST;
      ST_RST:           if (ph_q == RST_LAST) state_d = ST_WAIT_ACT;
      ST_WAIT_ACT: begin
        if (cpu_active)             state_d = ST_RUN;
        else if (ph_q == WAIT_LAST) state_d = ST_DONE;
      end
      ST_RUN: begin
        if (!cpu_active)                         state_d = ST_DRAIN;
        else if ((timeout_q != '0) && cnt_hit_c) state_d = ST_DONE;
      end
      ST_DRAIN:         state_d = ST_DONE;
      default:          state_d = ST_IDLE;
    endcase
  end

  // Registered outputs are decoded from the next state so they line up with it.
  always_comb begin
    cpu_reset_d      = 1'b1;
    cpu_clk_enable_d = 1'b0;
    busy_d           = 1'b0;
    done_d           = 1'b0;
    status_d         = status_q;
    result_v0_d      = result_v0_q;
    timeout_d        = timeout_q;
    ph_d             = '0;

    case (state_d)
      ST_RST: begin
        cpu_clk_enable_d = 1'b1;
        busy_d           = 1'b1;
      end
      ST_WAIT_ACT, ST_RUN, ST_DRAIN: begin
        cpu_reset_d      = 1'b0;
        cpu_clk_enable_d = 1'b1;
        busy_d           = 1'b1;
      end
      ST_DONE: begin
        cpu_reset_d = 1'b0;
        done_d      = 1'b1;
      end
      default: ;
    endcase

    if (start_acc_c) begin
      status_d    = STATUS_OK;
      result_v0_d = '0;
      timeout_d   = timeout_cycles;
    end

    case (state_q)
      ST_RST: if (state_d == ST_RST) ph_d = ph_q + PH_WIDTH'(1);
      ST_WAIT_ACT: begin
        if (state_d == ST_WAIT_ACT)  ph_d = ph_q + PH_WIDTH'(1);
        else if (state_d == ST_DONE) status_d = STATUS_NO_ACTIVE;
      end
      ST_RUN: begin
        if (state_d == ST_DONE) begin
          status_d    = STATUS_TIMEOUT;
          result_v0_d = cpu_register_v0;
        end
      end
      ST_DRAIN: begin
        result_v0_d = cpu_register_v0;
        status_d    = mismatch_c ? STATUS_MISMATCH : STATUS_OK;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cpu_reset_q      <= 1'b1;
      cpu_clk_enable_q <= 1'b0;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
      status_q         <= STATUS_OK;
      result_v0_q      <= '0;
      timeout_q        <= '0;
      ph_q             <= '0;
    end else begin
      cpu_reset_q      <= cpu_reset_d;
      cpu_clk_enable_q <= cpu_clk_enable_d;
      busy_q           <= busy_d;
      done_q           <= done_d;
      status_q         <= status_d;
      result_v0_q      <= result_v0_d;
      timeout_q        <= timeout_d;
      ph_q             <= ph_d;
    end
  end

  assign cpu_reset      = cpu_reset_q;
  assign cpu_clk_enable = cpu_clk_enable_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign status         = status_q;
  assign result_v0      = result_v0_q;
  assign cycle_count    = cnt_val;

endmodule

// File: tb/tb_mips_cpu_run_monitor.sv
// Scoreboard bench for mips_cpu_run_monitor: stub CPUs, directed runs, and a
// monitor that checks each completed run and each reset snapshot.
module tb_mips_cpu_run_monitor;

  localparam int unsigned DW  = 32;
  localparam int unsigned CW  = 32;
  localparam int unsigned CW4 = 4;

`ifdef MIPS_RUN_MONITOR_COMPARE_EN
  localparam logic [1:0] MIS_STATUS = 2'd3;
`else
  localparam logic [1:0] MIS_STATUS = 2'd0;
`endif

  typedef struct {
    string       name;
    logic [1:0]  status;
    logic [31:0] result;
    logic [31:0] count;
    int          done_cyc;
  } exp_t;

  typedef struct {
    string       name;
    logic [69:0] vec;
  } snap_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          start4 = 1'b0;
  logic [CW-1:0] timeout_cycles = '0;
  logic [CW4-1:0] timeout4 = '0;
  logic [DW-1:0] expected_v0 = '0;
  logic [DW-1:0] expected4 = '0;

  logic          cpu_reset, cpu_clk_enable, busy, done;
  logic [1:0]    status;
  logic [DW-1:0] result_v0;
  logic [CW-1:0] cycle_count;
  logic          cpu_reset4, cpu_clk_enable4, busy4, done4;
  logic [1:0]    status4;
  logic [DW-1:0] result4;
  logic [CW4-1:0] count4;

  // Stub CPUs: active for len enabled cycles after reset (or forever), one-shot per arm.
  logic          arm = 1'b0, fvr = 1'b0, s_active = 1'b0;
  int            len = 0, s_cnt = 0;
  logic [DW-1:0] v0 = '0;
  logic          arm4 = 1'b0, s_active4 = 1'b0;
  int            len4 = 0, s_cnt4 = 0;
  logic [DW-1:0] v0_4 = '0;

  always @(posedge clk) begin
    if (arm) begin
      s_cnt <= 0; s_active <= 1'b0;
    end else if (cpu_reset) begin
      s_active <= 1'b0;
    end else if (cpu_clk_enable) begin
      if (fvr || (s_cnt < len)) begin
        s_active <= 1'b1; s_cnt <= s_cnt + 1;
      end else begin
        s_active <= 1'b0;
      end
    end
  end

  always @(posedge clk) begin
    if (arm4) begin
      s_cnt4 <= 0; s_active4 <= 1'b0;
    end else if (cpu_reset4) begin
      s_active4 <= 1'b0;
    end else if (cpu_clk_enable4) begin
      if (s_cnt4 < len4) begin
        s_active4 <= 1'b1; s_cnt4 <= s_cnt4 + 1;
      end else begin
        s_active4 <= 1'b0;
      end
    end
  end

  mips_cpu_run_monitor dut (
    .clk(clk), .reset(reset), .start(start), .timeout_cycles(timeout_cycles),
    .expected_v0(expected_v0), .cpu_active(s_active), .cpu_register_v0(v0),
    .cpu_reset(cpu_reset), .cpu_clk_enable(cpu_clk_enable), .busy(busy), .done(done),
    .status(status), .result_v0(result_v0), .cycle_count(cycle_count)
  );

  mips_cpu_run_monitor #(.CNT_WIDTH(CW4)) dut4 (
    .clk(clk), .reset(reset), .start(start4), .timeout_cycles(timeout4),
    .expected_v0(expected4), .cpu_active(s_active4), .cpu_register_v0(v0_4),
    .cpu_reset(cpu_reset4), .cpu_clk_enable(cpu_clk_enable4), .busy(busy4), .done(done4),
    .status(status4), .result_v0(result4), .cycle_count(count4)
  );

  int    cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  exp_t  run_q[$];
  exp_t  run4_q[$];
  snap_t snap_q[$];
  int    n_checks = 0;
  int    n_pass = 0;
  logic  final_req = 1'b0;

  function automatic void chk(input string nm, input logic [127:0] act, input logic [127:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, req);
  endfunction

  // Monitor: compares on reset snapshots and on each rising done.
  logic done_prev = 1'b0, done4_prev = 1'b0, final_seen = 1'b0;
  always @(negedge clk) begin
    snap_t s;
    exp_t  e;
    if (reset && (snap_q.size() != 0)) begin
      s = snap_q.pop_front();
      chk(s.name, 128'({cpu_reset, cpu_clk_enable, busy, done, status, result_v0, cycle_count}),
          128'(s.vec));
    end
    if (done && !done_prev) begin
      if (run_q.size() == 0) chk("unexpected_done", 128'(1), 128'(0));
      else begin
        e = run_q.pop_front();
        chk({e.name, ".status"}, 128'(status), 128'(e.status));
        chk({e.name, ".result"}, 128'(result_v0), 128'(e.result));
        chk({e.name, ".count"}, 128'(cycle_count), 128'(e.count));
        chk({e.name, ".done_cycle"}, 128'(cyc), 128'(e.done_cyc));
        chk({e.name, ".ctrl"}, 128'({cpu_reset, cpu_clk_enable, busy}), 128'(3'b000));
      end
    end
    if (done4 && !done4_prev) begin
      if (run4_q.size() == 0) chk("unexpected_done4", 128'(1), 128'(0));
      else begin
        e = run4_q.pop_front();
        chk({e.name, ".status"}, 128'(status4), 128'(e.status));
        chk({e.name, ".result"}, 128'(result4), 128'(e.result));
        chk({e.name, ".count"}, 128'(count4), 128'(e.count));
        chk({e.name, ".done_cycle"}, 128'(cyc), 128'(e.done_cyc));
        chk({e.name, ".ctrl"}, 128'({cpu_reset4, cpu_clk_enable4, busy4}), 128'(3'b000));
      end
    end
    done_prev  = done;
    done4_prev = done4;
    if (final_req && !final_seen) begin
      final_seen = 1'b1;
      chk("pending", 128'(run_q.size() + run4_q.size() + snap_q.size()), 128'(0));
    end
  end

  task automatic launch(input string nm, input bit push, input int l, input bit f,
                        input logic [31:0] v, input logic [31:0] ex, input logic [31:0] tmo,
                        input logic [1:0] st, input logic [31:0] res, input logic [31:0] cnt,
                        input int off);
    exp_t e;
    @(negedge clk); arm = 1'b1; len = l; fvr = f; v0 = v;
    @(negedge clk); arm = 1'b0; timeout_cycles = tmo; expected_v0 = ex; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    if (push) begin
      e.name = nm; e.status = st; e.result = res; e.count = cnt; e.done_cyc = cyc + off;
      run_q.push_back(e);
    end
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if ((run_q.size() == 0) && (run4_q.size() == 0)) break;
    end
    @(negedge clk);
  endtask

  initial begin
    snap_t s;
    exp_t  e;
    s.name = "reset_state"; s.vec = {1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0};
    snap_q.push_back(s);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Active 21 cycles: one spent in WAIT_ACT, 20 counted; a mid-run start is ignored.
    launch("ok_run", 1'b1, 21, 1'b0, 32'd7, 32'd7, 32'd100, 2'd0, 32'd7, 32'd20, 25);
    repeat (10) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle(200);

    launch("no_active", 1'b1, 0, 1'b0, 32'hdead, 32'h0, 32'd100, 2'd1, 32'd0, 32'd0, 3);
    wait_idle(200);

    launch("timeout", 1'b1, 0, 1'b1, 32'h1234, 32'h1234, 32'd50, 2'd2, 32'h1234, 32'd50, 53);
    wait_idle(200);

    launch("v0_compare", 1'b1, 5, 1'b0, 32'd5, 32'd6, 32'd100, MIS_STATUS, 32'd5, 32'd4, 9);
    wait_idle(200);

    launch("no_timeout", 1'b1, 130, 1'b0, 32'hcafe, 32'hcafe, 32'd0, 2'd0, 32'hcafe, 32'd129, 134);
    wait_idle(300);

    // Abort with reset after 10 RUN cycles; checked before any further clock edge.
    launch("abort", 1'b0, 40, 1'b0, 32'd3, 32'd3, 32'd100, 2'd0, 32'd0, 32'd0, 0);
    repeat (13) @(posedge clk);
    #1 reset = 1'b1;
    s.name = "abort_reset"; s.vec = {1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0};
    snap_q.push_back(s);
    repeat (3) @(negedge clk);
    reset = 1'b0;

    launch("after_abort", 1'b1, 8, 1'b0, 32'd9, 32'd9, 32'd100, 2'd0, 32'd9, 32'd7, 12);
    wait_idle(200);

    // 4-bit counter, no timeout, 30 counted cycles saturate at 15.
    @(negedge clk); arm4 = 1'b1; len4 = 31; v0_4 = 32'h55;
    @(negedge clk); arm4 = 1'b0; timeout4 = 4'd0; expected4 = 32'h55; start4 = 1'b1;
    @(posedge clk); #1; start4 = 1'b0;
    e.name = "saturate"; e.status = 2'd0; e.result = 32'h55; e.count = 32'd15;
    e.done_cyc = cyc + 35;
    run4_q.push_back(e);
    wait_idle(200);

    final_req = 1'b1;
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
